// File: rtl/mac_accum_32.sv
// Signed multiply-accumulate over a burst of LEN operand pairs; result held on acc_out
// until the downstream register takes it. Define SATURATE_EN for clamping adds with a sticky ovf.
module mac_accum_32 #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              busy,
  output logic              ovf
);

  // Handshake: an operand pair moves on a clock edge where in_valid && in_ready;
  // the result is taken on an edge where out_valid && out_ready.
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state, state_nxt;
  logic [ACC_W-1:0]   acc;
  logic [LEN_W-1:0]   cnt;
  logic               beat;
  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   acc_add;
  logic               clamp;

  assign beat     = (state == ACCUM) && in_valid;
  assign prod     = $signed(a) * $signed(b);
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

`ifdef SATURATE_EN
  logic [ACC_W:0] sum_ext;
  logic           ovf_q;

  // One guard bit: guard and MSB disagree exactly when the signed add overflows.
  assign sum_ext = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};
  assign clamp   = sum_ext[ACC_W] != sum_ext[ACC_W-1];
  always_comb begin
    acc_add = sum_ext[ACC_W-1:0];
    if (clamp)
      acc_add = sum_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
  assign ovf = ovf_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ovf_q <= 1'b0;
    else if (state == IDLE && start)
      ovf_q <= 1'b0;
    else if (beat && clamp)
      ovf_q <= 1'b1;
  end
`else
  assign clamp   = 1'b0;
  assign acc_add = acc + prod_ext;
  assign ovf     = clamp;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len == '0) ? DONE : ACCUM;
      ACCUM:   if (beat && cnt == LEN_W'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && start) begin
        acc <= '0;
        cnt <= len;
      end else if (beat) begin
        acc <= acc_add;
        cnt <= cnt - LEN_W'(1);
      end
    end
  end

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign acc_out   = out_valid ? acc : '0;

endmodule
